// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with two write ports, NUM_RD
// combinational read ports, optional write-to-read bypass, optional
// hardwired-zero register 0 and a per-register pending-write scoreboard.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   regWrite0/writeReg0/writeData0 write port 0
//   regWrite1/writeReg1/writeData1 write port 1 (wins on same address)
//   readReg  [NUM_RD*ADDR_W]      packed read addresses, port k at k*ADDR_W
//   readData [NUM_RD*DATA_W]      packed read data, port k at k*DATA_W
//   reserve/reserveReg            mark a register as awaiting a write
//   busy     [NUM_RD]             read port k addresses a pending register
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     regWrite0,
   input  logic [ADDR_W-1:0]        writeReg0,
   input  logic [DATA_W-1:0]        writeData0,
   input  logic                     regWrite1,
   input  logic [ADDR_W-1:0]        writeReg1,
   input  logic [DATA_W-1:0]        writeData1,
   input  logic [NUM_RD*ADDR_W-1:0] readReg,
   output logic [NUM_RD*DATA_W-1:0] readData,
   input  logic                     reserve,
   input  logic [ADDR_W-1:0]        reserveReg,
   output logic [NUM_RD-1:0]        busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;

   logic we0;
   logic we1;
   logic rsv;

   // Accesses to register 0 are dropped entirely when it is hardwired.
   assign we0 = regWrite0 && !((ZERO_REG != 0) && (writeReg0 == '0));
   assign we1 = regWrite1 && !((ZERO_REG != 0) && (writeReg1 == '0));
   assign rsv = reserve && !((ZERO_REG != 0) && (reserveReg == '0));

   // A reservation is applied last: it belongs to a newer producer than
   // any write landing in the same cycle.
   always_comb begin
      pend_d = pend_q;
      if (we0) pend_d[writeReg0] = 1'b0;
      if (we1) pend_d[writeReg1] = 1'b0;
      if (rsv) pend_d[reserveReg] = 1'b1;
   end

   // Port 1 is written after port 0 so it wins on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         if (we0) regs_q[writeReg0] <= writeData0;
         if (we1) regs_q[writeReg1] <= writeData1;
         pend_q <= pend_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              zero;
      logic              hit0;
      logic              hit1;

      assign addr = readReg[k*ADDR_W +: ADDR_W];
      assign zero = (ZERO_REG != 0) && (addr == '0);
      assign hit1 = (BYPASS != 0) && we1 && (writeReg1 == addr);
      assign hit0 = (BYPASS != 0) && we0 && (writeReg0 == addr);

      // Reset gating also covers data being forwarded from the write ports.
      assign readData[k*DATA_W +: DATA_W] =
         (rst || zero) ? '0         :
         hit1          ? writeData1 :
         hit0          ? writeData0 :
                         regs_q[addr];

      // A forwarded write satisfies the reader, so it is not busy.
      assign busy[k] = !(rst || zero || hit0 || hit1) && pend_q[addr];
   end

endmodule
